// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus per-bit hold-time filter for the slide switches feeding the PIO in_port.
// SWITCH_DEBOUNCE_EDGE_IRQ_EN adds the sticky edge_capture register and irq; otherwise both read 0.
module switch_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic [WIDTH-1:0] clr_edge,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_changed,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] sw_stable_next;
  logic [WIDTH-1:0] sw_changed_next;

  // Any cycle of agreement restarts the count, so only uninterrupted disagreement is accepted.
  always_comb begin
    sw_stable_next  = sw_stable;
    sw_changed_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != sw_stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          sw_stable_next[i]  = sync2[i];
          sw_changed_next[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= '0;
      sync2      <= '0;
      sw_stable  <= '0;
      sw_changed <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1      <= sw_raw;
      sync2      <= sync1;
      sw_stable  <= sw_stable_next;
      sw_changed <= sw_changed_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
  logic [WIDTH-1:0] edge_capture_next;

  // A new change outranks a clear landing on the same edge so no event is lost.
  assign edge_capture_next = (edge_capture & ~clr_edge) | sw_changed_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      edge_capture <= edge_capture_next;
      irq          <= |edge_capture_next;
    end
  end
`else
  logic unused_clr_edge;

  assign unused_clr_edge = ^clr_edge;
  assign edge_capture    = '0;
  assign irq             = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4; edge/irq expectations follow the build macro.
module tb_switch_debounce;

  localparam int W  = 8;
  localparam int DB = 4;
`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic         clk      = 1'b0;
  logic         reset_n  = 1'b0;
  logic [W-1:0] sw_raw   = '0;
  logic [W-1:0] clr_edge = '0;
  logic [W-1:0] sw_stable;
  logic [W-1:0] sw_changed;
  logic [W-1:0] edge_capture;
  logic         irq;

  int n_cmp = 0;
  int n_bad = 0;

  switch_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (20)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_raw      (sw_raw),
    .clr_edge    (clr_edge),
    .sw_stable   (sw_stable),
    .sw_changed  (sw_changed),
    .edge_capture(edge_capture),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (stable,changed,edge,irq)", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {7'b0, sw_stable, sw_changed, edge_capture, irq};
  endfunction

  function automatic logic [31:0] want(input logic [7:0] st, input logic [7:0] ch,
                                       input logic [7:0] ec, input logic iq);
    return {7'b0, st, ch, (EN ? ec : 8'h00), (EN ? iq : 1'b0)};
  endfunction

  initial begin
    repeat (3) tick();
    check_eq("reset", obs(), want(8'h00, 8'h00, 8'h00, 1'b0));
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("idle", obs(), want(8'h00, 8'h00, 8'h00, 1'b0));
    end

    // Step to 0x05: accepted on E0+5, strobe for exactly that one cycle.
    sw_raw = 8'h05;
    for (int t = 0; t <= 6; t++) begin
      tick();
      if (t < 5)       check_eq("step_wait", obs(), want(8'h00, 8'h00, 8'h00, 1'b0));
      else if (t == 5) check_eq("step_hit",  obs(), want(8'h05, 8'h05, 8'h05, 1'b1));
      else             check_eq("step_post", obs(), want(8'h05, 8'h00, 8'h05, 1'b1));
    end

    // Bit 7 glitches of 3 clocks with 1-clock gaps never reach the count limit.
    for (int r = 0; r < 13; r++) begin
      for (int p = 0; p < 4; p++) begin
        sw_raw = (p < 3) ? 8'h85 : 8'h05;
        tick();
        check_eq("glitch", obs(), want(8'h05, 8'h00, 8'h05, 1'b1));
      end
    end
    sw_raw = 8'h05;
    repeat (3) begin
      tick();
      check_eq("glitch_tail", obs(), want(8'h05, 8'h00, 8'h05, 1'b1));
    end

    clr_edge = 8'h01;
    tick();
    clr_edge = 8'h00;
    check_eq("clr_bit0", obs(), want(8'h05, 8'h00, 8'h04, 1'b1));

    // Release bit 2 and clear it on the very edge its change lands: set wins.
    sw_raw = 8'h01;
    for (int t = 0; t <= 5; t++) begin
      clr_edge = (t == 5) ? 8'h04 : 8'h00;
      tick();
      if (t < 5) check_eq("fall_wait", obs(), want(8'h05, 8'h00, 8'h04, 1'b1));
      else       check_eq("set_wins",  obs(), want(8'h01, 8'h04, 8'h04, 1'b1));
    end
    clr_edge = 8'h04;
    tick();
    clr_edge = 8'h00;
    check_eq("clr_irq_low", obs(), want(8'h01, 8'h00, 8'h00, 1'b0));

    // Bit 3 reaches count 3 of 4, then reset aborts it.
    sw_raw = 8'h09;
    for (int t = 0; t <= 4; t++) begin
      tick();
      check_eq("pre_rst", obs(), want(8'h01, 8'h00, 8'h00, 1'b0));
    end
    reset_n = 1'b0;
    sw_raw  = 8'h08;
    #1;
    check_eq("async_rst", obs(), 32'h0);
    tick();
    check_eq("in_rst", obs(), 32'h0);
    reset_n = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t < 6)       check_eq("rel_wait", obs(), want(8'h00, 8'h00, 8'h00, 1'b0));
      else if (t == 6) check_eq("rel_hit",  obs(), want(8'h08, 8'h08, 8'h08, 1'b1));
      else             check_eq("rel_post", obs(), want(8'h08, 8'h00, 8'h08, 1'b1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Per-bit synchronizer and debouncer for the board slide switches, sitting directly upstream of the switch PIO and driving its `in_port`. Each raw, asynchronous switch bit is double-flopped into `clk`, then filtered by a per-bit counter so that only levels held for `DEBOUNCE_CYCLES` consecutive clocks reach the PIO. It also emits one-cycle change strobes and, optionally, a sticky edge-capture register with an interrupt.

## Interface
- `WIDTH`, 8, number of switch bits.
- `DEBOUNCE_CYCLES`, 500000, consecutive cycles of disagreement required before accepting a new level (10 ms at 50 MHz); legal range ≥1.
- `CNT_W`, 20, counter width; must satisfy 2^CNT_W > `DEBOUNCE_CYCLES`.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `sw_raw`  in  WIDTH  raw switch pins, asynchronous to `clk`.
- `clr_edge`  in  WIDTH  per-bit write-one-to-clear for `edge_capture`.
- `sw_stable`  out  WIDTH  debounced level; connects to PIO `in_port`.
- `sw_changed`  out  WIDTH  one-cycle strobe per bit when `sw_stable` bit toggles.
- `edge_capture`  out  WIDTH  sticky per-bit change flags.
- `irq`  out  1  OR-reduction of `edge_capture`.

## Operation
- Reset drives every register to 0: `sync1`, `sync2`, `sw_stable`, all counters, `sw_changed`, `edge_capture`, and `irq`.
- Synchronizer: `sync1 <= sw_raw`, `sync2 <= sync1`. No logic sits between the two flops.
- Per-bit filter, evaluated every clock:
  - If `sync2[i] == sw_stable[i]`, `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `sw_stable[i] <= sync2[i]`, `cnt[i] <= 0`, and `sw_changed[i] <= 1`.
  - Else `cnt[i] <= cnt[i]+1`.
- `sw_changed[i]` is 0 in every cycle except the one following a toggle of `sw_stable[i]`.
- A single cycle of agreement restarts the count from zero, so a glitch shorter than `DEBOUNCE_CYCLES` never reaches `sw_stable`.
- The counter never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- Bits are fully independent. Any number of bits may toggle in the same cycle.
- Edge capture (see Configuration):
  - `edge_capture[i] <= (edge_capture[i] & ~clr_edge[i]) | sw_changed_next[i]`. When a set and a clear of the same bit coincide, the set wins.
  - `irq` is registered: `irq <= |edge_capture_next`.
- Post-reset behaviour: a switch held high through reset appears as a 0→1 transition. After `DEBOUNCE_CYCLES+2` clocks it produces a `sw_changed` strobe and sets the edge flag. This is intended; software clears it at init.
- Reset asserted mid-count aborts the count. All state returns to 0 immediately and asynchronously.

## Timing
- `sw_raw` changes before edge E0 and then holds:
  - `sync2` reflects the new level after E0+1.
  - `sw_stable` and `sw_changed` update at edge E0+1+`DEBOUNCE_CYCLES`.
  - `edge_capture` and `irq` update on that same edge.
- Total latency is `DEBOUNCE_CYCLES+2` clocks from the first sampling edge, excluding metastability resolution.
- With `DEBOUNCE_CYCLES`=1, `sw_stable` follows `sync2` one clock later.
- `clr_edge` takes effect on the next edge. `irq` deasserts on that same edge if no other flag remains set.
- No combinational path exists from any input to any output.

## Configuration
- Macro: `SWITCH_DEBOUNCE_EDGE_IRQ_EN`.
- Defined: the `edge_capture` register, clear logic and `irq` are implemented as described above.
- Undefined: `edge_capture` is tied to 0 and `irq` is tied to 0. `clr_edge` is ignored. The port list is unchanged. `sw_stable` and `sw_changed` behave identically in both builds.

## Test plan
- Reset with `sw_raw`=0x00 and `DEBOUNCE_CYCLES`=4, hold 20 clocks:
  - `sw_stable`=0x00, `sw_changed`=0x00, `edge_capture`=0x00, `irq`=0 throughout.
- From that state, step `sw_raw` to 0x05 just before an edge E0:
  - `sw_stable`=0x05 at E0+5.
  - `sw_changed`=0x05 for exactly one cycle.
  - `edge_capture`=0x05 and `irq`=1 from E0+5.
- Glitches on bit 7 of 3 clocks (after sync), repeated with 1-clock gaps, for 50 clocks:
  - `sw_stable[7]` stays 0; `sw_changed[7]` is never set.
- With `edge_capture`=0x05, pulse `clr_edge`=0x01 for one clock:
  - `edge_capture`=0x04 and `irq`=1.
  - Then pulse `clr_edge`=0x04 on the same cycle `sw_changed[2]` fires: bit 2 stays set (set wins).
- Assert `reset_n` low for 1 clock while bit 3 has counted 3 of 4:
  - All outputs read 0 immediately.
  - After release with `sw_raw`=0x08, `sw_stable`=0x08 after 6 clocks.
- Build without `SWITCH_DEBOUNCE_EDGE_IRQ_EN` and repeat the second scenario:
  - `sw_stable` and `sw_changed` are identical to the enabled build.
  - `edge_capture`=0x00 and `irq`=0 always.
